// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the counter-based clock divider.
// Holds FSM states, ratio selects and the period-boundary test.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOPPED,
    RUN,
    PEND,
    DRAIN
  } state_e;

  localparam logic [1:0] SEL_DIV2  = 2'd0;
  localparam logic [1:0] SEL_DIV4  = 2'd1;
  localparam logic [1:0] SEL_DIV8  = 2'd2;
  localparam logic [1:0] SEL_DIV16 = 2'd3;

  function automatic logic [31:0] bnd_mask(
    input logic [31:0] sel
  );
    return (32'd2 << sel) - 32'd1;
  endfunction

  // Last cycle of the high phase for the given select.
  function automatic logic at_boundary(
    input logic [31:0] cnt,
    input logic [31:0] sel
  );
    logic [31:0] m;
    m = bnd_mask(sel);
    return (cnt & m) == m;
  endfunction

endpackage

// File: rtl/div_counter.sv
// Free-running power-of-two divide counter with tap mux.
// div_clk/div_tick are registered from next-state values.
module div_counter #(
  parameter int CNT_W = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] cnt,
  output logic             div_clk,
  output logic             div_tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clk_q;
  logic             clk_d;
  logic             tick_q;
  logic             tick_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
    clk_d  = cnt_d[sel];
    tick_d = clk_d & ~clk_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign cnt      = cnt_q;
  assign div_clk  = clk_q;
  assign div_tick = tick_q;

endmodule

// File: rtl/clock_div_sequencer.sv
// Run/stop and ratio sequencer for the clock divider.
// All start, stop and ratio changes land on period boundaries.
module clock_div_sequencer
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int SEL_W     = 2,
  parameter int RESET_SEL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             div_clk,
  output logic             div_tick,
  output logic [SEL_W-1:0] cur_sel,
  output logic             running
);

  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);

  function automatic logic [SEL_W-1:0] clamp_sel(
    input logic [SEL_W-1:0] s
  );
    if (32'(s) > 32'(CNT_W - 1)) begin
      return SEL_W'(CNT_W - 1);
    end
    return s;
  endfunction

  state_e           state_q;
  state_e           state_d;
  logic [SEL_W-1:0] cur_sel_q;
  logic [SEL_W-1:0] cur_sel_d;
  logic [SEL_W-1:0] pend_sel_q;
  logic [SEL_W-1:0] pend_sel_d;
  logic             done_q;
  logic             done_d;

  logic             inc;
  logic             clr;
  logic             bnd;
  logic             accept;
  logic [SEL_W-1:0] req_sel;
  logic [CNT_W-1:0] cnt;

  assign cfg_ready = (state_q == STOPPED) || (state_q == RUN);
  assign accept    = cfg_valid & cfg_ready;
  assign req_sel   = clamp_sel(cfg_sel);
  assign bnd       = at_boundary(32'(cnt), 32'(cur_sel_q));

  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    done_d     = 1'b0;
    inc        = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      STOPPED: begin
        clr = 1'b1;
        if (accept) begin
          cur_sel_d = req_sel;
          done_d    = 1'b1;
        end
        if (run_en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        inc = 1'b1;
        if (accept && (req_sel != cur_sel_q)) begin
          pend_sel_d = req_sel;
          state_d    = PEND;
        end else begin
          done_d = accept;
          if (!run_en) begin
            state_d = DRAIN;
          end
        end
      end
      PEND: begin
        inc = 1'b1;
        if (bnd) begin
          clr       = 1'b1;
          cur_sel_d = pend_sel_q;
          done_d    = 1'b1;
          state_d   = run_en ? RUN : STOPPED;
        end
      end
      DRAIN: begin
        inc = 1'b1;
        if (run_en) begin
          state_d = RUN;
        end else if (bnd) begin
          clr     = 1'b1;
          state_d = STOPPED;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= STOPPED;
      cur_sel_q  <= RST_SEL;
      pend_sel_q <= RST_SEL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      done_q     <= done_d;
    end
  end

  // Tap follows the next-state select so div_clk has no lag.
  div_counter #(
    .CNT_W(CNT_W),
    .SEL_W(SEL_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc),
    .clr     (clr),
    .sel     (cur_sel_d),
    .cnt     (cnt),
    .div_clk (div_clk),
    .div_tick(div_tick)
  );

  assign cfg_done = done_q;
  assign cur_sel  = cur_sel_q;
  assign running  = (state_q != STOPPED);

endmodule

// File: tb/tb_clock_div_sequencer.sv
// Self-checking bench for clock_div_sequencer.
// Reference model tracks period position and ratio arithmetically.
module tb_clock_div_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_en;
  logic       cfg_valid;
  logic [1:0] cfg_sel;
  logic       cfg_ready;
  logic       cfg_done;
  logic       div_clk;
  logic       div_tick;
  logic [1:0] cur_sel;
  logic       running;

  int checks = 0;
  int errors = 0;

  clock_div_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .run_en   (run_en),
    .cfg_valid(cfg_valid),
    .cfg_sel  (cfg_sel),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .div_clk  (div_clk),
    .div_tick (div_tick),
    .cur_sel  (cur_sel),
    .running  (running)
  );

  always #5 clk = ~clk;

  bit m_run, m_pend, m_drain, m_done, m_dclk, m_tick, m_acc;
  int m_sel, m_psel, m_pos;
  logic [6:0] obs;
  logic [6:0] expv;

  assign obs = {div_clk, div_tick, cfg_ready, cfg_done, running, cur_sel};

  function automatic bit m_ready();
    return !m_run || !(m_pend || m_drain);
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_drain = 0; m_done = 0;
    m_dclk = 0; m_tick = 0; m_acc = 0;
    m_sel = 0; m_psel = 0; m_pos = 0;
    expv = 7'b0010000;
  endtask

  // Advance one clock; model consumes inputs seen at the edge.
  task automatic tick();
    int r, cs;
    bit acc, bnd, ren, dnew;
    @(posedge clk);
    ren = run_en;
    cs = int'(cfg_sel);
    acc = cfg_valid && m_ready();
    r = 2 << m_sel;
    bnd = m_run && ((m_pos % r) == r - 1);
    m_done = 0;
    m_acc = acc;
    if (!m_run) begin
      if (acc) begin m_sel = cs; m_done = 1; end
      if (ren) begin m_run = 1; m_pos = 0; end
    end else if (m_pend) begin
      if (bnd) begin
        m_sel = m_psel; m_pos = 0; m_done = 1;
        m_pend = 0; m_run = ren;
      end else m_pos++;
    end else if (m_drain) begin
      if (ren) begin m_drain = 0; m_pos++; end
      else if (bnd) begin m_run = 0; m_drain = 0; m_pos = 0; end
      else m_pos++;
    end else begin
      m_pos++;
      if (acc && cs != m_sel) begin
        m_pend = 1; m_psel = cs;
      end else begin
        if (acc) m_done = 1;
        if (!ren) m_drain = 1;
      end
    end
    r = 2 << m_sel;
    dnew = m_run && ((m_pos % r) >= r / 2);
    m_tick = dnew && !m_dclk;
    m_dclk = dnew;
    expv = {m_dclk, m_tick, m_ready(), m_done, m_run, 2'(m_sel)};
    #1;
  endtask

  task automatic set_ratio(input int s);
    cfg_valid = 1; cfg_sel = 2'(s);
    tick();
    cfg_valid = 0;
    for (int i = 0; i < 40 && !m_done && m_sel != s; i++) tick();
    for (int i = 0; i < 40 && (m_pend || !m_run); i++) tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 7'b0010000);
    end
    #13 reset = 1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL idle obs=%b exp=%b cyc=%0d", obs, expv, i);
      end
    end
  endtask

  task automatic test_div2();
    int nt = 0;
    run_en = 1;
    tick();
    checks++;
    if (div_clk !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL div2_start clk=%b run=%b exp 0/1", div_clk, running);
    end
    for (int i = 0; i < 500; i++) begin
      tick();
      nt += int'(div_tick);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL div2 obs=%b exp=%b cyc=%0d", obs, expv, i);
      end
    end
    checks++;
    if (nt != 250) begin
      errors++;
      $display("FAIL div2_ticks got=%0d exp=250", nt);
    end
  endtask

  task automatic test_div8();
    int rl = 0, nd = 0;
    cfg_valid = 1; cfg_sel = 2'd2;
    for (int i = 0; i < 24; i++) begin
      tick();
      cfg_valid = 0;
      rl += int'(!cfg_ready);
      nd += int'(cfg_done);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL div8 obs=%b exp=%b cyc=%0d", obs, expv, i);
      end
    end
    checks++;
    if (rl < 1 || rl > 2 || nd != 1 || cur_sel !== 2'd2) begin
      errors++;
      $display("FAIL div8_switch rdy_low=%0d done=%0d sel=%0d exp 1..2/1/2",
               rl, nd, cur_sel);
    end
  endtask

  task automatic test_div16_to_2();
    int nd = 0;
    bit ok = 0;
    set_ratio(3);
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_run && !m_pend && m_sel == 3 && (m_pos % 16) == 9) ok = 1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL div16_wait cnt9 not reached got=0 exp=1");
    end
    cfg_valid = 1; cfg_sel = 2'd0;
    tick();
    cfg_sel = 2'd1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (div_clk !== 1'b1 || obs !== expv) begin
        errors++;
        $display("FAIL div16_high clk=%b obs=%b exp=%b i=%0d",
                 div_clk, obs, expv, i);
      end
      tick();
    end
    checks++;
    if (div_clk !== 1'b0 || cfg_done !== 1'b1 || cur_sel !== 2'd0) begin
      errors++;
      $display("FAIL div16_switch clk=%b done=%b sel=%0d exp 0/1/0",
               div_clk, cfg_done, cur_sel);
    end
    nd = int'(cfg_done);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL div16_second obs=%b exp=%b", obs, expv);
      end
      if (m_acc) begin
        ok = 1;
        cfg_valid = 0;
      end else nd += int'(cfg_done);
    end
    checks++;
    if (!ok || nd != 1) begin
      errors++;
      $display("FAIL div16_second_accept acc=%0d done=%0d exp 1/1", ok, nd);
    end
  endtask

  task automatic test_drain();
    bit ok = 0;
    set_ratio(1);
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_run && !m_pend && (m_pos % 4) == 1) ok = 1;
      else tick();
    end
    run_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (running !== (i < 2) || obs !== expv) begin
        errors++;
        $display("FAIL drain run=%b obs=%b exp=%b i=%0d",
                 running, obs, expv, i);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (div_clk !== 1'b0 || div_tick !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL stopped clk=%b tick=%b run=%b exp 0/0/0",
                 div_clk, div_tick, running);
      end
    end
    run_en = 1;
    tick();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if ((m_pos % 4) == 1) ok = 1;
      else tick();
    end
    run_en = 0;
    tick();
    run_en = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (running !== 1'b1 || obs !== expv) begin
        errors++;
        $display("FAIL blip run=%b obs=%b exp=%b i=%0d",
                 running, obs, expv, i);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if (!cfg_valid) begin
        cfg_valid = ($urandom % 8) == 0;
        cfg_sel = 2'($urandom);
      end
      if (($urandom % 16) == 0) run_en = ~run_en;
      tick();
      if (m_acc) cfg_valid = 0;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random obs=%b exp=%b cyc=%0d", obs, expv, i);
      end
    end
    cfg_valid = 0;
  endtask

  task automatic test_reset_pend();
    bit ok = 0;
    run_en = 1;
    set_ratio(3);
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_run && !m_pend && !m_drain && (m_pos % 16) == 0) ok = 1;
      else tick();
    end
    cfg_valid = 1; cfg_sel = 2'd0;
    tick();
    cfg_valid = 0;
    tick(); tick(); tick();
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL pend_entry ready=%b exp=0", cfg_ready);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (obs !== 7'b0010000) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=%b", obs, 7'b0010000);
    end
    model_reset();
    run_en = 0;
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (cfg_done !== 1'b0 || cur_sel !== 2'd0 || obs !== expv) begin
        errors++;
        $display("FAIL post_reset done=%b sel=%0d obs=%b exp=%b",
                 cfg_done, cur_sel, obs, expv);
      end
    end
  endtask

  initial begin
    reset = 0;
    run_en = 0;
    cfg_valid = 0;
    cfg_sel = 2'd0;
    model_reset();
    test_reset();
    test_idle();
    test_div2();
    test_div8();
    test_div16_to_2();
    test_drain();
    test_random();
    test_reset_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_sequencer.md
Name: clock_div_sequencer

Overview:
- Run/stop and divide-ratio controller for the counter-based clock divider datapath.
- Owns a free-running power-of-two divide counter and selects one tap as the divided clock (/2, /4, /8, /16 by default).
- Ratio changes arrive on a valid/ready config handshake. Starts, stops and ratio changes take effect only at period boundaries, so div_clk never shows a runt or truncated phase.

Parameters:
- CNT_W, 4, divide counter width; ratio for select s is 2^(s+1), s = 0..CNT_W-1.
- SEL_W, 2, select width, equal to clog2(CNT_W).
- RESET_SEL, 0, ratio select loaded at reset (0 = /2).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- run_en  in  1  level; 1 = divider running, 0 = stop at next boundary
- cfg_valid  in  1  ratio-change request
- cfg_sel  in  SEL_W  requested ratio select; stable while cfg_valid=1
- cfg_ready  out  1  request can be accepted this cycle
- cfg_done  out  1  one-cycle pulse when the accepted ratio becomes active
- div_clk  out  1  divided clock (register output)
- div_tick  out  1  one-cycle pulse in the cycle div_clk is 1 after being 0
- cur_sel  out  SEL_W  currently applied ratio select
- running  out  1  1 in any state except STOPPED

Behaviour:
- Reset (reset=0, immediate, async):
  - state=STOPPED, cnt=0, cur_sel=RESET_SEL.
  - div_clk=0, div_tick=0, cfg_done=0.
  - Any pending config is discarded.
- Counter and boundary:
  - cnt increments by 1 every cycle in RUN, PEND and DRAIN, wrapping mod 2^CNT_W.
  - cnt is held at 0 in STOPPED.
  - div_clk always equals cnt[cur_sel]; it is registered from next-state values, so there is zero lag versus cnt.
  - mask = (2 << cur_sel) - 1. Boundary = (cnt & mask) == mask, i.e. the last cycle of the high phase.
- Handshake:
  - cfg_ready = 1 in STOPPED and RUN, 0 in PEND and DRAIN.
  - Accept = cfg_valid & cfg_ready.
- FSM:
  - STOPPED:
    - Accept: cur_sel <= cfg_sel; cfg_done pulses next cycle.
    - run_en=1: go to RUN. cnt=0 after that edge; div_clk first goes high one edge later.
    - Accept and run_en=1 together: both take effect.
  - RUN:
    - Accept with cfg_sel != cur_sel: latch pend_sel, go to PEND.
    - Accept with cfg_sel == cur_sel: cfg_done pulses next cycle, no disturbance to cnt or div_clk.
    - Otherwise, run_en=0: go to DRAIN.
    - Accept and run_en=0 in the same cycle: go to PEND.
  - PEND:
    - Wait for boundary under the old cur_sel.
    - At boundary: cur_sel <= pend_sel, cnt <= 0, cfg_done pulses the next cycle.
    - Then go to RUN if run_en=1, STOPPED if run_en=0.
  - DRAIN:
    - run_en returns to 1 before boundary: back to RUN, counting uninterrupted.
    - At boundary with run_en=0: cnt <= 0, go to STOPPED.
- Guarantees:
  - The old ratio's final high phase is always full length.
  - The new ratio starts with a full low phase.
  - No div_clk phase is shorter than min(old, new) half-period.
- Stop: div_clk stops low. Restart begins a full period from cnt=0.
- div_tick is asserted with each 0->1 transition of div_clk and never while STOPPED.
- Illegal cfg_sel values cannot occur while CNT_W is a power of two. If CNT_W is not a power of two, out-of-range values clamp to CNT_W-1.

Decomposition:
- Shared package clk_div_pkg holds:
  - state enum {STOPPED, RUN, PEND, DRAIN};
  - SEL_* ratio constants (SEL_DIV2=0 .. SEL_DIV16=3);
  - boundary-mask helper function.
- Sub-module div_counter: counter, tap mux and registered div_clk/div_tick, with inputs inc, clr, sel.
- The FSM and handshake stay in the top.

Test Plan:
- 10 ns clk; reset=0 for 14 ns then 1; run_en=0 -> div_clk=0, running=0, cur_sel=0, cfg_ready=1, held for 50 cycles.
- run_en=1 at /2 -> div_clk high 2 edges later, then 1-high/1-low; div_tick on every rising edge; 250 pulses in 500 cycles.
- Running /2, cfg_sel=2 (/8) accepted -> cfg_ready=0 for at most 2 cycles, one cfg_done pulse, then div_clk 4 low/4 high, cur_sel=2.
- Running /16, cfg_sel=0 accepted at cnt=9 -> div_clk stays high through cnt=15 (8-cycle high phase). A second cfg_valid held high is accepted only after cfg_done; no phase shorter than 1 cycle.
- Running /4, run_en=0 at cnt=1 -> DRAIN until cnt=3, then div_clk=0, running=0, no further div_tick. Separately, a run_en 0->1 blip before the boundary shows no gap in counting.
- reset=0 during PEND -> all outputs at reset values within the same cycle; after release cur_sel=RESET_SEL and cfg_done is never pulsed.
